// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: sensor/control inputs from the machine side, credit and pulse outputs back.
`timescale 1ns/1ps
interface coin_acceptor_if;
  logic       coin_sense;
  logic [1:0] coin_type;
  logic       refund_req;
  logic       vend_done;
  logic       coin_inserted;
  logic [7:0] credit;
  logic [7:0] change_out;
  logic       change_valid;
  logic       reject_coin;
  logic       busy;

  modport master (
    output coin_sense, coin_type, refund_req, vend_done,
    input  coin_inserted, credit, change_out, change_valid, reject_coin, busy
  );

  modport slave (
    input  coin_sense, coin_type, refund_req, vend_done,
    output coin_inserted, credit, change_out, change_valid, reject_coin, busy
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces the coin sensor, validates coins into credit, handles
// refund and vend. Optional change return on vend: define COIN_ACCEPTOR_CHANGE_RETURN_EN.
`timescale 1ns/1ps
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRICE           = 25,
  parameter int MAX_CREDIT      = 200
) (
  input  logic           clk,
  input  logic           reset,
  coin_acceptor_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    ACCEPT   = 3'd2,
    PAID     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  localparam logic [3:0] DEB_N  = 4'(DEBOUNCE_CYCLES);
  localparam logic [8:0] PRICE9 = 9'(PRICE);
  localparam logic [7:0] PRICE8 = 8'(PRICE);
  localparam logic [8:0] MAX9   = 9'(MAX_CREDIT);

  function automatic logic [8:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   coin_value = 9'd5;
      2'b01:   coin_value = 9'd10;
      2'b10:   coin_value = 9'd25;
      default: coin_value = 9'd0;
    endcase
  endfunction

  state_t     state_r;
  logic       sync1_r, sync2_r;
  logic [3:0] cnt_r;
  logic [7:0] credit_r, change_r;
  logic       inserted_r, change_valid_r, reject_r, busy_r;
  logic       held_r, go_paid_r;

  logic       slug_s, fits_s, qualify_s, refund_ok_s;
  logic [8:0] sum_s, new_credit_s;
  logic [7:0] remain_s;

  // Coin evaluation is done in 9 bits so credit+value never wraps before the ceiling test.
  assign slug_s       = (bus.coin_type == 2'b11);
  assign sum_s        = {1'b0, credit_r} + coin_value(bus.coin_type);
  assign fits_s       = !slug_s && (sum_s <= MAX9);
  assign new_credit_s = fits_s ? sum_s : {1'b0, credit_r};
  assign qualify_s    = sync2_r && ((cnt_r + 4'd1) == DEB_N);
  assign remain_s     = credit_r - PRICE8;
  assign refund_ok_s  = bus.refund_req && (credit_r != 8'd0) &&
                        ((state_r == IDLE) || (state_r == WAIT_LOW) ||
                         ((state_r == PAID) && !bus.vend_done));

  // Synchronizer, debounce counter, credit bookkeeping and the acceptor FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      sync1_r        <= 1'b0;
      sync2_r        <= 1'b0;
      cnt_r          <= 4'd0;
      credit_r       <= 8'd0;
      change_r       <= 8'd0;
      inserted_r     <= 1'b0;
      change_valid_r <= 1'b0;
      reject_r       <= 1'b0;
      busy_r         <= 1'b0;
      held_r         <= 1'b0;
      go_paid_r      <= 1'b0;
    end else begin
      sync1_r        <= bus.coin_sense;
      sync2_r        <= sync1_r;
      inserted_r     <= 1'b0;
      change_valid_r <= 1'b0;
      reject_r       <= 1'b0;
      if (refund_ok_s) begin
        change_r       <= credit_r;
        change_valid_r <= 1'b1;
        credit_r       <= 8'd0;
        cnt_r          <= 4'd0;
        held_r         <= 1'b0;
        state_r        <= sync2_r ? WAIT_LOW : IDLE;
        busy_r         <= sync2_r;
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r <= 4'd0;
            if (sync2_r) begin
              state_r <= DEBOUNCE;
              busy_r  <= 1'b1;
            end else begin
              busy_r  <= 1'b0;
            end
          end
          DEBOUNCE: begin
            if (!sync2_r) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              cnt_r   <= 4'd0;
            end else if (qualify_s) begin
              // The coin is judged on the qualifying edge; ACCEPT then routes onward.
              state_r <= ACCEPT;
              cnt_r   <= 4'd0;
              if (fits_s) begin
                credit_r <= new_credit_s[7:0];
              end else begin
                reject_r <= 1'b1;
              end
              if (new_credit_s >= PRICE9) begin
                inserted_r <= 1'b1;
                go_paid_r  <= 1'b1;
              end else begin
                go_paid_r  <= 1'b0;
              end
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
          ACCEPT: begin
            busy_r <= 1'b1;
            cnt_r  <= 4'd0;
            if (go_paid_r) begin
              state_r <= PAID;
              held_r  <= 1'b1;
            end else begin
              state_r <= WAIT_LOW;
            end
          end
          PAID: begin
            busy_r <= 1'b1;
            if (bus.vend_done) begin
`ifdef COIN_ACCEPTOR_CHANGE_RETURN_EN
              change_r       <= remain_s;
              change_valid_r <= (remain_s != 8'd0);
              credit_r       <= 8'd0;
`else
              credit_r       <= remain_s;
`endif
              cnt_r   <= 4'd0;
              held_r  <= 1'b0;
              state_r <= sync2_r ? WAIT_LOW : IDLE;
              busy_r  <= sync2_r;
            end else if (!sync2_r) begin
              held_r <= 1'b0;
              cnt_r  <= 4'd0;
            end else if (!held_r) begin
              // A further coin while paid is qualified, then diverted once until the sensor clears.
              if (qualify_s) begin
                reject_r <= 1'b1;
                held_r   <= 1'b1;
                cnt_r    <= 4'd0;
              end else begin
                cnt_r <= cnt_r + 4'd1;
              end
            end else begin
              cnt_r <= 4'd0;
            end
          end
          WAIT_LOW: begin
            cnt_r <= 4'd0;
            if (!sync2_r) begin
              if ({1'b0, credit_r} >= PRICE9) begin
                state_r    <= PAID;
                inserted_r <= 1'b1;
                held_r     <= 1'b0;
                busy_r     <= 1'b1;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              busy_r <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign bus.coin_inserted = inserted_r;
  assign bus.credit        = credit_r;
  assign bus.change_out    = change_r;
  assign bus.change_valid  = change_valid_r;
  assign bus.reject_coin   = reject_r;
  assign bus.busy          = busy_r;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: default instance plus a PRICE=MAX_CREDIT=200 instance for the ceiling.
`timescale 1ns/1ps
module tb_coin_acceptor;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_sense = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       refund_req = 1'b0;
  logic       vend_done = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int n_ins, n_rej, n_chg, h_ins, h_rej;
  logic [7:0] last_chg;

  always #5 clk = ~clk;

  coin_acceptor_if if0();
  coin_acceptor_if ifh();

  assign if0.coin_sense = coin_sense;
  assign if0.coin_type  = coin_type;
  assign if0.refund_req = refund_req;
  assign if0.vend_done  = vend_done;
  assign ifh.coin_sense = coin_sense;
  assign ifh.coin_type  = coin_type;
  assign ifh.refund_req = refund_req;
  assign ifh.vend_done  = vend_done;

  coin_acceptor dut (.clk(clk), .reset(reset), .bus(if0));
  coin_acceptor #(.DEBOUNCE_CYCLES(4), .PRICE(200), .MAX_CREDIT(200)) dut_hi (.clk(clk), .reset(reset), .bus(ifh));

  task automatic clear_counts();
    n_ins = 0; n_rej = 0; n_chg = 0; h_ins = 0; h_rej = 0; last_chg = 8'd0;
  endtask

  task automatic sample_cycle();
    @(posedge clk); #1;
    if (if0.coin_inserted) n_ins++;
    if (if0.reject_coin) n_rej++;
    if (if0.change_valid) begin n_chg++; last_chg = if0.change_out; end
    if (ifh.coin_inserted) h_ins++;
    if (ifh.reject_coin) h_rej++;
  endtask

  task automatic run_coin(input logic [1:0] t);
    clear_counts();
    @(negedge clk); coin_sense = 1'b1; coin_type = t;
    repeat (8) sample_cycle();
    @(negedge clk); coin_sense = 1'b0; coin_type = 2'b00;
    repeat (6) sample_cycle();
  endtask

  task automatic pulse_refund();
    clear_counts();
    @(negedge clk); refund_req = 1'b1;
    sample_cycle();
    @(negedge clk); refund_req = 1'b0;
    repeat (3) sample_cycle();
  endtask

  task automatic pulse_vend();
    clear_counts();
    @(negedge clk); vend_done = 1'b1;
    sample_cycle();
    @(negedge clk); vend_done = 1'b0;
    repeat (3) sample_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (if0.credit !== 8'd0) begin tests_failed++; $display("FAIL reset_credit: got %0d want 0", if0.credit); end
    tests_run++; if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
    tests_run++; if (if0.change_out !== 8'd0) begin tests_failed++; $display("FAIL reset_change_out: got %0d want 0", if0.change_out); end
    tests_run++; if ({if0.coin_inserted, if0.change_valid, if0.reject_coin} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_pulses: got %b want 000", {if0.coin_inserted, if0.change_valid, if0.reject_coin}); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_s1_latency();
    logic [7:0] exp_c;
    logic       exp_i, exp_b;
    @(negedge clk); coin_sense = 1'b1; coin_type = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      exp_c = (k >= 7) ? 8'd25 : 8'd0;
      exp_i = (k == 7);
      exp_b = (k >= 3);
      tests_run++; if (if0.credit !== exp_c) begin tests_failed++; $display("FAIL s1_credit edge %0d: got %0d want %0d", k, if0.credit, exp_c); end
      tests_run++; if (if0.coin_inserted !== exp_i) begin tests_failed++; $display("FAIL s1_inserted edge %0d: got %b want %b", k, if0.coin_inserted, exp_i); end
      tests_run++; if (if0.busy !== exp_b) begin tests_failed++; $display("FAIL s1_busy edge %0d: got %b want %b", k, if0.busy, exp_b); end
    end
    @(negedge clk); coin_sense = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests_run++; if (if0.credit !== 8'd25) begin tests_failed++; $display("FAIL s1_paid_credit: got %0d want 25", if0.credit); end
    tests_run++; if (if0.busy !== 1'b1) begin tests_failed++; $display("FAIL s1_paid_busy: got %b want 1", if0.busy); end
  endtask

  task automatic test_refund();
    pulse_refund();
    tests_run++; if (n_chg !== 1) begin tests_failed++; $display("FAIL refund_pulses: got %0d want 1", n_chg); end
    tests_run++; if (last_chg !== 8'd25) begin tests_failed++; $display("FAIL refund_amount: got %0d want 25", last_chg); end
    tests_run++; if (if0.credit !== 8'd0) begin tests_failed++; $display("FAIL refund_credit: got %0d want 0", if0.credit); end
    tests_run++; if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL refund_idle: got busy %b want 0", if0.busy); end
  endtask

  task automatic test_s2_glitch();
    clear_counts();
    repeat (3) begin
      @(negedge clk); coin_sense = 1'b1; coin_type = 2'b10;
      repeat (2) sample_cycle();
      @(negedge clk); coin_sense = 1'b0;
      repeat (4) sample_cycle();
    end
    tests_run++; if (if0.credit !== 8'd0) begin tests_failed++; $display("FAIL s2_credit: got %0d want 0", if0.credit); end
    tests_run++; if (n_ins + n_rej + n_chg !== 0) begin tests_failed++; $display("FAIL s2_pulses: got %0d want 0", n_ins + n_rej + n_chg); end
    tests_run++; if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL s2_busy: got %b want 0", if0.busy); end
  endtask

  task automatic test_s3_accumulate();
    run_coin(2'b00);
    tests_run++; if (if0.credit !== 8'd5) begin tests_failed++; $display("FAIL s3_credit1: got %0d want 5", if0.credit); end
    tests_run++; if (n_ins !== 0) begin tests_failed++; $display("FAIL s3_ins1: got %0d want 0", n_ins); end
    run_coin(2'b01);
    tests_run++; if (if0.credit !== 8'd15) begin tests_failed++; $display("FAIL s3_credit2: got %0d want 15", if0.credit); end
    tests_run++; if (n_ins !== 0) begin tests_failed++; $display("FAIL s3_ins2: got %0d want 0", n_ins); end
    run_coin(2'b01);
    tests_run++; if (if0.credit !== 8'd25) begin tests_failed++; $display("FAIL s3_credit3: got %0d want 25", if0.credit); end
    tests_run++; if (n_ins !== 1) begin tests_failed++; $display("FAIL s3_ins3: got %0d want 1", n_ins); end
    run_coin(2'b00);
    tests_run++; if (n_rej !== 1) begin tests_failed++; $display("FAIL paid_reject: got %0d want 1", n_rej); end
    tests_run++; if (if0.credit !== 8'd25) begin tests_failed++; $display("FAIL paid_credit: got %0d want 25", if0.credit); end
    tests_run++; if (n_ins !== 0) begin tests_failed++; $display("FAIL paid_no_repulse: got %0d want 0", n_ins); end
  endtask

  task automatic test_s4_vend();
    pulse_refund();
    tests_run++; if (last_chg !== 8'd25) begin tests_failed++; $display("FAIL s4_refund: got %0d want 25", last_chg); end
    run_coin(2'b01);
    run_coin(2'b10);
    tests_run++; if (if0.credit !== 8'd35) begin tests_failed++; $display("FAIL s4_credit35: got %0d want 35", if0.credit); end
    tests_run++; if (n_ins !== 1) begin tests_failed++; $display("FAIL s4_ins: got %0d want 1", n_ins); end
    pulse_vend();
`ifdef COIN_ACCEPTOR_CHANGE_RETURN_EN
    tests_run++; if (n_chg !== 1) begin tests_failed++; $display("FAIL s4_change_pulse: got %0d want 1", n_chg); end
    tests_run++; if (last_chg !== 8'd10) begin tests_failed++; $display("FAIL s4_change_out: got %0d want 10", last_chg); end
    tests_run++; if (if0.credit !== 8'd0) begin tests_failed++; $display("FAIL s4_vend_credit: got %0d want 0", if0.credit); end
    run_coin(2'b01);
`else
    tests_run++; if (n_chg !== 0) begin tests_failed++; $display("FAIL s4_change_pulse: got %0d want 0", n_chg); end
    tests_run++; if (if0.credit !== 8'd10) begin tests_failed++; $display("FAIL s4_vend_credit: got %0d want 10", if0.credit); end
`endif
    pulse_vend();
    tests_run++; if (if0.credit !== 8'd10) begin tests_failed++; $display("FAIL vend_outside_paid: got %0d want 10", if0.credit); end
    tests_run++; if (n_chg !== 0) begin tests_failed++; $display("FAIL vend_outside_chg: got %0d want 0", n_chg); end
    pulse_refund();
    tests_run++; if (last_chg !== 8'd10) begin tests_failed++; $display("FAIL s4_refund10: got %0d want 10", last_chg); end
    tests_run++; if (if0.credit !== 8'd0) begin tests_failed++; $display("FAIL s4_refund_credit: got %0d want 0", if0.credit); end
    pulse_refund();
    tests_run++; if (n_chg !== 0) begin tests_failed++; $display("FAIL refund_zero: got %0d pulses want 0", n_chg); end
  endtask

  task automatic test_s5_ceiling();
    do_reset();
    for (int i = 0; i < 7; i++) run_coin(2'b10);
    run_coin(2'b01);
    run_coin(2'b01);
    tests_run++; if (ifh.credit !== 8'd195) begin tests_failed++; $display("FAIL s5_credit195: got %0d want 195", ifh.credit); end
    run_coin(2'b10);
    tests_run++; if (h_rej !== 1) begin tests_failed++; $display("FAIL s5_over_reject: got %0d want 1", h_rej); end
    tests_run++; if (ifh.credit !== 8'd195) begin tests_failed++; $display("FAIL s5_over_credit: got %0d want 195", ifh.credit); end
    run_coin(2'b11);
    tests_run++; if (h_rej !== 1) begin tests_failed++; $display("FAIL s5_slug_reject: got %0d want 1", h_rej); end
    tests_run++; if (ifh.credit !== 8'd195) begin tests_failed++; $display("FAIL s5_slug_credit: got %0d want 195", ifh.credit); end
    run_coin(2'b00);
    tests_run++; if (ifh.credit !== 8'd200) begin tests_failed++; $display("FAIL s5_exact_max: got %0d want 200", ifh.credit); end
    tests_run++; if (h_ins !== 1 || h_rej !== 0) begin tests_failed++; $display("FAIL s5_exact_pulses: got ins %0d rej %0d want 1 0", h_ins, h_rej); end
  endtask

  task automatic test_s6_reset_debounce();
    do_reset();
    run_coin(2'b01);
    tests_run++; if (if0.credit !== 8'd10) begin tests_failed++; $display("FAIL s6_pre_credit: got %0d want 10", if0.credit); end
    @(negedge clk); coin_sense = 1'b1; coin_type = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    tests_run++; if (if0.busy !== 1'b1) begin tests_failed++; $display("FAIL s6_debounce_busy: got %b want 1", if0.busy); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if (if0.credit !== 8'd0) begin tests_failed++; $display("FAIL s6_reset_credit: got %0d want 0", if0.credit); end
    tests_run++; if ({if0.busy, if0.coin_inserted, if0.change_valid, if0.reject_coin} !== 4'b0000) begin
      tests_failed++; $display("FAIL s6_reset_outputs: got %b want 0000", {if0.busy, if0.coin_inserted, if0.change_valid, if0.reject_coin}); end
    tests_run++; if (if0.change_out !== 8'd0) begin tests_failed++; $display("FAIL s6_reset_change: got %0d want 0", if0.change_out); end
    clear_counts();
    repeat (2) sample_cycle();
    @(negedge clk); reset = 1'b1;
    repeat (10) sample_cycle();
    @(negedge clk); coin_sense = 1'b0; coin_type = 2'b00;
    repeat (6) sample_cycle();
    tests_run++; if (if0.credit !== 8'd10) begin tests_failed++; $display("FAIL s6_held_coin_once: got %0d want 10", if0.credit); end
    tests_run++; if (n_rej !== 0) begin tests_failed++; $display("FAIL s6_no_reject: got %0d want 0", n_rej); end
    tests_run++; if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL s6_final_idle: got %b want 0", if0.busy); end
  endtask

  initial begin
    test_reset();
    test_s1_latency();
    test_refund();
    test_s2_glitch();
    test_s3_accumulate();
    test_s4_vend();
    test_s5_ceiling();
    test_s6_reset_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Upstream stage of vending_machine_fsm. Turns raw coin-sensor activity into validated credit and raises coin_inserted once the price is covered.

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4 (range 1..15), the number of consecutive synchronized-high samples needed to qualify a coin.
REQ-002 The block SHALL have parameter PRICE, default 25, the item price in cents (range 1..MAX_CREDIT).
REQ-003 The block SHALL have parameter MAX_CREDIT, default 200, the credit ceiling in cents (at most 255).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have the following ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_sense  in  1  raw, asynchronous coin-present sensor.
- coin_type  in  2  denomination, meaningful while coin_sense is high: 00=5, 01=10, 10=25, 11=slug.
- refund_req  in  1  level; return all credit.
- vend_done  in  1  one-cycle pulse from the vending FSM (dispense_item).
- coin_inserted  out  1  one-cycle pulse, feeds vending_machine_fsm.
- credit  out  8  current credit in cents.
- change_out  out  8  amount returned; valid only while change_valid is high.
- change_valid  out  1  one-cycle pulse.
- reject_coin  out  1  one-cycle pulse; the physical coin is diverted to the return chute.
- busy  out  1  high in every state except IDLE.

Function
REQ-005 coin_sense SHALL pass through a 2-flop synchronizer before any use.
REQ-006 The FSM SHALL have states IDLE, DEBOUNCE, ACCEPT, PAID and WAIT_LOW.
REQ-007 IDLE -> DEBOUNCE SHALL occur when the synchronized sense is high; the debounce counter clears.
REQ-008 In DEBOUNCE, the counter SHALL increment each cycle the sense is high; a low sample SHALL return the FSM to IDLE with no credit change (glitch).
REQ-009 When the counter reaches DEBOUNCE_CYCLES, the FSM SHALL sample coin_type and go to ACCEPT.
REQ-010 Latency: credit SHALL update on rising edge DEBOUNCE_CYCLES+3, counting edge 1 as the first edge that samples coin_sense high.
REQ-011 ACCEPT SHALL pulse reject_coin with credit unchanged when the sampled type is a slug, or when credit+value > MAX_CREDIT; otherwise credit SHALL become credit+value.
REQ-012 Credit arithmetic SHALL use 9 bits internally so the sum never wraps.
REQ-013 If credit >= PRICE after ACCEPT, coin_inserted SHALL pulse on the same edge credit updates, and the FSM SHALL go to PAID; otherwise it SHALL go to WAIT_LOW.
REQ-014 coin_inserted SHALL pulse exactly once per PAID entry.
REQ-015 WAIT_LOW SHALL hold until the synchronized sense is low, then return to IDLE (or PAID if credit >= PRICE); one physical coin SHALL never count twice.
REQ-016 In PAID, any qualified coin SHALL be rejected (reject_coin pulse, credit unchanged); coin_inserted SHALL not re-pulse.
REQ-017 In PAID, vend_done SHALL deduct PRICE from credit and then act as defined in Configuration; the FSM SHALL then go to IDLE (or WAIT_LOW if sense is high).
REQ-018 refund_req with credit > 0, in IDLE, WAIT_LOW or PAID, SHALL give change_out=credit, pulse change_valid, clear credit and go to IDLE (or WAIT_LOW if sense is high).
REQ-019 refund_req with credit = 0 SHALL produce no change_valid pulse.
REQ-020 refund_req SHALL be ignored in DEBOUNCE and ACCEPT and SHALL be honoured on the first eligible cycle if still high.
REQ-021 When vend_done and refund_req are high together, vend_done SHALL win; refund then applies to any remaining credit on the next cycle.
REQ-022 vend_done outside PAID SHALL be ignored.

Reset
REQ-023 reset low SHALL immediately force state IDLE, credit=0, counter=0, synchronizer=0, change_out=0, and all pulse outputs and busy low.
REQ-024 Reset mid-DEBOUNCE or mid-ACCEPT SHALL discard the coin with no reject_coin pulse.
REQ-025 After release, a coin_sense that is already high SHALL be treated as a new coin.

Configuration
REQ-026 With macro COIN_ACCEPTOR_CHANGE_RETURN_EN defined, vend_done in PAID SHALL produce change_out=credit−PRICE, pulse change_valid when that value is > 0, and leave credit=0.
REQ-027 Without COIN_ACCEPTOR_CHANGE_RETURN_EN, change on vend_done SHALL be omitted and credit SHALL retain credit−PRICE as carry-over; refund via refund_req SHALL still operate.

Verification
REQ-028 The bench SHALL cover these scenarios (defaults; macro defined unless stated):
- S1: coin_sense high for 10 cycles with type 10 (25) -> credit 25 and coin_inserted pulse on edge 7, then PAID.
- S2: coin_sense high-pulses of 2 cycles -> no credit change, no pulses.
- S3: type 00, then 01, then 01 (5+10+10) -> coin_inserted only after the third coin, credit 25.
- S4: PAID with credit 35, then vend_done -> change_valid with change_out 10, credit 0; without the macro, credit 10 and no change_valid.
- S5: credit 195 plus a 25 coin -> reject_coin pulse, credit stays 195; type 11 -> reject_coin pulse.
- S6: reset low during DEBOUNCE -> all outputs 0 immediately; held coin after release -> credited once.
